// File: rtl/serial_frame_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// serial_frame_ctrl_pkg
//   Shared definitions for the serial receive sequencer.
//   - state_t          : FSM state encoding (IDLE/START/DATA/STOP)
//   - DATA_BITS_DEF    : default data bits per frame
//   - CYC_PER_BIT_DEF  : default clock cycles per serial bit
// ----------------------------------------------------------------------------
package serial_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS_DEF   = 8;
    localparam int CYC_PER_BIT_DEF = 4;

endpackage

// File: rtl/serial_frame_ctrl_sipo.sv
// ----------------------------------------------------------------------------
// sipo_shift_en
//   Serial-in / parallel-out shift register with a shift enable.
//   On each enabled edge the serial bit enters bit 0 and older bits move
//   toward the MSB, so the first bit received ends up in the MSB.
// Ports:
//   i_clk        system clock (rising edge)
//   i_reset      asynchronous active-high reset, clears the register
//   i_shift_en   1 = shift in i_serial_in on this edge
//   i_serial_in  serial data bit
//   o_par_out    parallel contents of the register
// ----------------------------------------------------------------------------
module sipo_shift_en
    import serial_frame_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_shift_en,
    input  logic                 i_serial_in,
    output logic [DATA_BITS-1:0] o_par_out
);

    logic [DATA_BITS-1:0] r_shift;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= '0;
        end else if (i_shift_en) begin
            r_shift <= {r_shift[DATA_BITS-2:0], i_serial_in};
        end
    end

    assign o_par_out = r_shift;

endmodule

// File: rtl/serial_frame_ctrl.sv
// ----------------------------------------------------------------------------
// serial_frame_ctrl
//   Receive-side sequencer: detects a start bit on an idle-high line, samples
//   DATA_BITS data bits (MSB first) and one stop bit at mid-bit, shifts them
//   into a SIPO register and moves the finished word into a holding register
//   offered downstream over a valid/ready handshake.
//
//   Handshake: rx_valid=1 means rx_data holds a word and stays constant; the
//   word is consumed on any edge where rx_valid && rx_ready. A new word may be
//   loaded on the same edge the old one is consumed.
//
// Ports:
//   clk         system clock (rising edge)
//   reset       asynchronous active-high reset
//   enable      1 = receiver active, 0 = FSM forced to IDLE
//   serial_in   serial line (idle high)
//   clr_status  synchronous clear of frame_err / overrun (set wins)
//   rx_ready    downstream ready
//   rx_data     received word
//   rx_valid    holding register full
//   busy        FSM not in IDLE (registered)
//   frame_err   sticky: stop bit sampled low
//   overrun     sticky: word dropped because holding register was full
// ----------------------------------------------------------------------------
module serial_frame_ctrl
    import serial_frame_ctrl_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int CYC_PER_BIT = CYC_PER_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 serial_in,
    input  logic                 clr_status,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CYC_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Counter reload values: the counter is sampled when it reads zero, so a
    // reload of N-1 places the next sample N edges later.
    localparam logic [CW-1:0] C_HALF_M1 = CW'(CYC_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_BIT_M1  = CW'(CYC_PER_BIT - 1);
    localparam logic [BW-1:0] C_LAST    = BW'(DATA_BITS - 1);

    state_t               r_state;
    logic [CW-1:0]        r_cyc_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_sample;
    logic                 w_shift_en;
    logic                 w_stop_ok;
    logic                 w_stop_bad;
    logic                 w_overrun_set;
    logic [DATA_BITS-1:0] w_word;

    assign w_sample   = (r_cyc_cnt == '0);
    assign w_shift_en = enable && (r_state == ST_DATA) && w_sample;
    assign w_stop_ok  = enable && (r_state == ST_STOP) && w_sample && serial_in;
    assign w_stop_bad = enable && (r_state == ST_STOP) && w_sample && !serial_in;
    assign w_overrun_set = w_stop_ok && r_rx_valid && !rx_ready;

    sipo_shift_en #(
        .DATA_BITS (DATA_BITS)
    ) u_sipo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_shift_en  (w_shift_en),
        .i_serial_in (serial_in),
        .o_par_out   (w_word)
    );

    // Frame sequencer: state, sample timing and bit counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cyc_cnt <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
        end else if (!enable) begin
            // Abort any partial frame silently.
            r_state   <= ST_IDLE;
            r_cyc_cnt <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!serial_in) begin
                        r_state   <= ST_START;
                        r_cyc_cnt <= C_HALF_M1;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_sample) begin
                        if (serial_in) begin
                            // Line went back high before mid-bit: glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= ST_DATA;
                            r_cyc_cnt <= C_BIT_M1;
                            r_bit_cnt <= '0;
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_cyc_cnt <= C_BIT_M1;
                        if (r_bit_cnt == C_LAST) begin
                            r_state   <= ST_STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_sample) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cyc_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Holding register, handshake and sticky status. Keeps running while
    // enable=0 so a held word can still be drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_stop_ok && (!r_rx_valid || rx_ready)) begin
                r_rx_data  <= w_word;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            // A set event on the same edge as clr_status takes priority.
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (clr_status) begin
                r_frame_err <= 1'b0;
            end

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (clr_status) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
